mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multi-cycle main control unit that drives the MIPS datapath's control inputs in place of a bench. It accepts one instruction word per valid/ready handshake, latches it into an instruction register, and sequences `ALUScr`, `RegDst`, `RegWrite`, `MemRead`, `MemWrite`, `MemtoReg` and `ALUControl` through decode, execute, memory and write-back states. It sits directly upstream of `datapath`: its `instr_q` output feeds the datapath `instruction` port, and it consumes the datapath `Zero` flag.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `instruction`  in  32  candidate instruction word.
- `instr_valid`  in  1  `instruction` is valid.
- `instr_ready`  out  1  controller can accept an instruction (IDLE only).
- `Zero`  in  1  datapath ALU zero flag.
- `instr_q`  out  32  latched instruction register, drives datapath `instruction`.
- `ALUScr`, `RegDst`, `RegWrite`, `MemRead`, `MemWrite`, `MemtoReg`  out  1 each  datapath controls.
- `ALUControl`  out  4  ALU operation code.
- `branch_taken`  out  1  one-cycle pulse: beq resolved taken.
- `done`  out  1  one-cycle pulse in the last state of each legal instruction.
- `illegal`  out  1  one-cycle pulse: unsupported opcode or funct.
- `instr_count`  out  CNT_W  count of legal instructions completed.

## Operation
- States: IDLE, DECODE, EXEC, MEM, WB.
- IDLE: `instr_ready=1`. On `instr_valid`, load `instr_q` and go to DECODE.
- DECODE: check the opcode `instr_q[31:26]`, plus funct for R-type.
  - Illegal: pulse `illegal`, return to IDLE, assert no write strobe.
  - Otherwise go to EXEC.
- Supported instructions:
  - R-type (0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04.
  - addi 0x08 (only with the configuration macro).
- `ALUControl` codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
  - lw, sw and addi use ADD; beq uses SUB.
- Paths:
  - R-type and addi: EXEC → WB → IDLE.
  - lw: EXEC → MEM → WB → IDLE.
  - sw: EXEC → MEM → IDLE.
  - beq: EXEC → IDLE. `branch_taken = Zero` is sampled in EXEC.
- Moore outputs are decoded from the state register and `instr_q`.
- Mux selects hold steady from EXEC until the instruction's final state:
  - `ALUScr=1` for lw, sw and addi.
  - `RegDst=1` for R-type.
  - `MemtoReg=1` for lw.
- `MemRead=1` in MEM and WB for lw.
- `MemWrite=1` only in MEM for sw.
- `RegWrite=1` only in WB.
- `done` pulses in the final state. `instr_count` increments on that same clock edge and wraps at 2^CNT_W.

## Timing
- Reset (asynchronous, on `rst=0`, including mid-instruction):
  - state is forced to IDLE; `instr_q` = 0; `instr_count` = 0.
  - every control output, `branch_taken`, `done` and `illegal` = 0.
  - `instr_ready` = 1 once `rst=1`.
  - No partial write strobe may survive reset.
- Latency from the accept edge to the `done` cycle:
  - R-type and addi: 3 cycles.
  - lw: 4 cycles.
  - sw: 3 cycles.
  - beq: 2 cycles.
- `illegal` asserts 1 cycle after the accept edge.
- `instruction` and `instr_valid` are ignored outside IDLE; there is no buffering.
- The controller is back-to-back capable: the cycle after the final state is IDLE, so the next accept takes effect on the next edge.
- `Zero` is only sampled in EXEC for beq.

## Configuration
- `MIPS_CTRL_ADDI_EN` defined: opcode 0x08 is legal. It sequences as ALUScr=1, RegDst=0, ADD, then WB.
- Undefined: 0x08 is treated as illegal (`illegal` pulse, no writes).

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode and funct localparams;
  - `ALUControl` code constants;
  - the state enum typedef.
- Sub-module `alu_control_dec` is a combinational mapping of (opcode, funct) to `ALUControl` and a legal flag.
- FSM, instruction register and counter live in the top module.

## Test plan
- lw `0x8C080005`, with datapath memory[5]=0x10:
  - EXEC has ALUScr=1 and ALUControl=0010.
  - MEM asserts MemRead.
  - WB asserts RegWrite=1 with MemtoReg=1; `$t0` becomes 0x00000010.
  - `done` fires on cycle 4 and `instr_count` becomes 1.
- add `0x02324820`, with $s1=4 and $s2=2:
  - RegDst=1 and ALUControl=0010.
  - RegWrite appears for exactly 1 cycle; $t1 = 6.
- sub `0x02325022` issued back-to-back after the add:
  - ALUControl=0110 and $t2 = 2.
  - `instr_ready` returns to 1 exactly 1 cycle after the add's WB.
- beq `0x12320003`:
  - With Zero=1 in EXEC, `branch_taken` pulses.
  - With Zero=0, no pulse.
  - In both cases RegWrite and MemWrite stay 0.
- Illegal opcode `0xFC000000`:
  - `illegal` pulses on cycle 1 and there are no write strobes.
  - `instr_count` is unchanged.
  - Repeat with 0x08 with and without `MIPS_CTRL_ADDI_EN`.
- Reset mid-operation: assert `rst=0` during MEM of a sw.
  - MemWrite drops immediately (asynchronously).
  - State returns to IDLE, `instr_q`=0, and `instr_count`=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS main controller: opcodes, funct codes,
// ALU operation codes and FSM states. Opcode 0x08 (addi) is legal only with MIPS_CTRL_ADDI_EN.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

endpackage

// File: rtl/alu_control_dec.sv
// Combinational (opcode, funct) -> ALU operation code and legality flag.
// Opcode 0x08 (addi) decodes as legal ADD only when MIPS_CTRL_ADDI_EN is defined.
module alu_control_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  // Instruction-set lookup; anything unlisted is illegal with a neutral AND code
  always_comb begin
    alu_ctrl = ALU_AND;
    legal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin alu_ctrl = ALU_ADD; legal = 1'b1; end
          FN_SUB:  begin alu_ctrl = ALU_SUB; legal = 1'b1; end
          FN_AND:  begin alu_ctrl = ALU_AND; legal = 1'b1; end
          FN_OR:   begin alu_ctrl = ALU_OR;  legal = 1'b1; end
          FN_SLT:  begin alu_ctrl = ALU_SLT; legal = 1'b1; end
          default: begin alu_ctrl = ALU_AND; legal = 1'b0; end
        endcase
      end
      OP_LW:   begin alu_ctrl = ALU_ADD; legal = 1'b1; end
      OP_SW:   begin alu_ctrl = ALU_ADD; legal = 1'b1; end
      OP_BEQ:  begin alu_ctrl = ALU_SUB; legal = 1'b1; end
`ifdef MIPS_CTRL_ADDI_EN
      OP_ADDI: begin alu_ctrl = ALU_ADD; legal = 1'b1; end
`else
      OP_ADDI: begin alu_ctrl = ALU_AND; legal = 1'b0; end
`endif
      default: begin alu_ctrl = ALU_AND; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main controller: instruction register, IDLE/DECODE/EXEC/MEM/WB FSM and
// retired-instruction counter. Build with MIPS_CTRL_ADDI_EN to make addi (0x08) legal.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             Zero,
  output logic [31:0]      instr_q,
  output logic             ALUScr,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic [3:0]       ALUControl,
  output logic             branch_taken,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [31:0]      instr_q_r;
  logic [CNT_W-1:0] instr_count_r;
  logic [3:0]       alu_ctrl_s;
  logic             legal_s;
  logic             is_r_s;
  logic             is_lw_s;
  logic             is_sw_s;
  logic             is_beq_s;
  logic             is_addi_s;
  logic             in_flight_s;
  logic             done_s;

  alu_control_dec u_alu_control_dec (
    .opcode   (instr_q_r[31:26]),
    .funct    (instr_q_r[5:0]),
    .alu_ctrl (alu_ctrl_s),
    .legal    (legal_s)
  );

  assign is_r_s    = legal_s && (instr_q_r[31:26] == OP_RTYPE);
  assign is_lw_s   = legal_s && (instr_q_r[31:26] == OP_LW);
  assign is_sw_s   = legal_s && (instr_q_r[31:26] == OP_SW);
  assign is_beq_s  = legal_s && (instr_q_r[31:26] == OP_BEQ);
  assign is_addi_s = legal_s && (instr_q_r[31:26] == OP_ADDI);

  // State, instruction register and retired counter; reset clears every strobe source at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      instr_q_r     <= 32'h0000_0000;
      instr_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_IDLE) && instr_valid) begin
        instr_q_r <= instruction;
      end
      if (done_s) begin
        instr_count_r <= instr_count_r + CNT_W'(1);
      end
    end
  end

  // Next-state sequencing per instruction class
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (instr_valid) state_nxt_s = ST_DECODE;
        else             state_nxt_s = ST_IDLE;
      end
      ST_DECODE: begin
        if (legal_s) state_nxt_s = ST_EXEC;
        else         state_nxt_s = ST_IDLE;
      end
      ST_EXEC: begin
        if (is_lw_s || is_sw_s) state_nxt_s = ST_MEM;
        else if (is_beq_s)      state_nxt_s = ST_IDLE;
        else                    state_nxt_s = ST_WB;
      end
      ST_MEM: begin
        if (is_lw_s) state_nxt_s = ST_WB;
        else         state_nxt_s = ST_IDLE;
      end
      ST_WB:   state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Moore control decode; mux selects hold from EXEC through the final state
  always_comb begin
    instr_ready  = (state_r == ST_IDLE);
    in_flight_s  = (state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB);
    ALUScr       = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    ALUControl   = 4'b0000;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    done_s       = 1'b0;
    if (in_flight_s) begin
      ALUScr     = is_lw_s || is_sw_s || is_addi_s;
      RegDst     = is_r_s;
      MemtoReg   = is_lw_s;
      ALUControl = alu_ctrl_s;
    end else begin
      ALUScr     = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUControl = 4'b0000;
    end
    case (state_r)
      ST_DECODE: illegal = !legal_s;
      ST_EXEC: begin
        branch_taken = is_beq_s && Zero;
        done_s       = is_beq_s;
      end
      ST_MEM: begin
        MemRead  = is_lw_s;
        MemWrite = is_sw_s;
        done_s   = is_sw_s;
      end
      ST_WB: begin
        MemRead  = is_lw_s;
        RegWrite = 1'b1;
        done_s   = 1'b1;
      end
      default: done_s = 1'b0;
    endcase
  end

  assign done        = done_s;
  assign instr_q     = instr_q_r;
  assign instr_count = instr_count_r;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: a per-instruction reference model pushes the
// expected retirement record; a negedge monitor accumulates strobes and compares on done/illegal.
module tb_mips_multicycle_control;

  localparam logic [3:0] E_AND = 4'b0000;
  localparam logic [3:0] E_OR  = 4'b0001;
  localparam logic [3:0] E_ADD = 4'b0010;
  localparam logic [3:0] E_SUB = 4'b0110;
  localparam logic [3:0] E_SLT = 4'b0111;

  typedef struct {
    logic [31:0] instr;
    bit          legal;
    int          dur;
    int          ev_cyc;
    logic [3:0]  alu;
    int          n_src, n_dst, n_m2r, n_rw, n_mr, n_mw, n_bt;
    logic [31:0] cnt_before;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        Zero;
  logic [31:0] instr_q;
  logic        ALUScr, RegDst, RegWrite, MemRead, MemWrite, MemtoReg;
  logic [3:0]  ALUControl;
  logic        branch_taken, done, illegal;
  logic [31:0] instr_count;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [31:0] mcount = 32'd0;
  int          a_src, a_dst, a_m2r, a_rw, a_mr, a_mw, a_bt;
  logic [3:0]  a_alu;

  mips_multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Zero(Zero), .instr_q(instr_q),
    .ALUScr(ALUScr), .RegDst(RegDst), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUControl(ALUControl),
    .branch_taken(branch_taken), .done(done), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: what the spec says one instruction should produce over its lifetime
  function automatic exp_t model(logic [31:0] i, bit z, int c, logic [31:0] cnt);
    exp_t e;
    logic [5:0] op, f;
    bit r, lw, sw, bq, ad;
    op = i[31:26]; f = i[5:0];
    r = 0; lw = 0; sw = 0; bq = 0; ad = 0;
    e.instr = i; e.cnt_before = cnt; e.legal = 1; e.alu = E_AND;
    if (op == 6'h00) begin
      r = 1;
      case (f)
        6'h20: e.alu = E_ADD;
        6'h22: e.alu = E_SUB;
        6'h24: e.alu = E_AND;
        6'h25: e.alu = E_OR;
        6'h2A: e.alu = E_SLT;
        default: e.legal = 0;
      endcase
    end else if (op == 6'h23) begin lw = 1; e.alu = E_ADD; end
    else if (op == 6'h2B) begin sw = 1; e.alu = E_ADD; end
    else if (op == 6'h04) begin bq = 1; e.alu = E_SUB; end
`ifdef MIPS_CTRL_ADDI_EN
    else if (op == 6'h08) begin ad = 1; e.alu = E_ADD; end
`endif
    else e.legal = 0;
    if (!e.legal) begin
      r = 0; e.alu = E_AND; e.dur = 1;
    end else begin
      e.dur = lw ? 4 : (bq ? 2 : 3);
    end
    e.ev_cyc = c + e.dur;
    e.n_src  = (lw || sw || ad) ? e.dur - 1 : 0;
    e.n_dst  = r ? 2 : 0;
    e.n_m2r  = lw ? 3 : 0;
    e.n_rw   = (r || lw || ad) ? 1 : 0;
    e.n_mr   = lw ? 2 : 0;
    e.n_mw   = sw ? 1 : 0;
    e.n_bt   = (bq && z) ? 1 : 0;
    return e;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        r[31:26] = 6'h00;
        case ($urandom_range(0, 4))
          0: r[5:0] = 6'h20;
          1: r[5:0] = 6'h22;
          2: r[5:0] = 6'h24;
          3: r[5:0] = 6'h25;
          default: r[5:0] = 6'h2A;
        endcase
      end
      3: r[31:26] = 6'h00;
      4: r[31:26] = 6'h23;
      5: r[31:26] = 6'h2B;
      6: r[31:26] = 6'h04;
      7: r[31:26] = 6'h08;
      default: ;
    endcase
    return r;
  endfunction

  task automatic clear_acc();
    a_src = 0; a_dst = 0; a_m2r = 0; a_rw = 0; a_mr = 0; a_mw = 0; a_bt = 0; a_alu = 4'b0000;
  endtask

  // Monitor: accumulate strobes each cycle, score on every done/illegal pulse
  initial begin
    exp_t e;
    clear_acc();
    forever begin
      @(negedge clk);
      if (!mon_en || !rst) begin
        clear_acc();
      end else begin
        a_src += int'(ALUScr); a_dst += int'(RegDst); a_m2r += int'(MemtoReg);
        a_rw += int'(RegWrite); a_mr += int'(MemRead); a_mw += int'(MemWrite);
        a_bt += int'(branch_taken); a_alu |= ALUControl;
        if (done || illegal) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: got done=%0b illegal=%0b expected no event", done, illegal);
          end else begin
            e = q.pop_front();
            chk("event_kind", {30'd0, done, illegal}, {30'd0, e.legal, !e.legal});
            chk("event_cycle", cyc, e.ev_cyc);
            chk("instr_q", instr_q, e.instr);
            chk("alu_ctrl", {28'd0, a_alu}, {28'd0, e.alu});
            chk("alusrc_cycles", a_src, e.n_src);
            chk("regdst_cycles", a_dst, e.n_dst);
            chk("memtoreg_cycles", a_m2r, e.n_m2r);
            chk("regwrite_cycles", a_rw, e.n_rw);
            chk("memread_cycles", a_mr, e.n_mr);
            chk("memwrite_cycles", a_mw, e.n_mw);
            chk("branch_taken", a_bt, e.n_bt);
            chk("instr_count", instr_count, e.cnt_before);
          end
          clear_acc();
        end
      end
    end
  end

  // Issue one instruction after g idle cycles; garbage is driven while the controller is busy
  task automatic issue(input logic [31:0] ins, input bit z, input int g);
    exp_t e;
    repeat (g) begin
      instr_valid = 1'b0; instruction = $urandom; Zero = 1'($urandom);
      @(posedge clk); #1;
    end
    instruction = ins; instr_valid = 1'b1; Zero = 1'($urandom);
    e = model(ins, z, cyc, mcount);
    q.push_back(e);
    if (e.legal) mcount = mcount + 32'd1;
    @(negedge clk);
    chk("ready_idle", {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < e.dur; k++) begin
      instr_valid = 1'($urandom); instruction = $urandom;
      Zero = (k == 1) ? z : 1'($urandom);
      @(negedge clk);
      chk("ready_busy", {31'd0, instr_ready}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_mid_sw();
    mon_en = 1'b0;
    instruction = 32'hAC09_0004; instr_valid = 1'b1; Zero = 1'b0;
    @(posedge clk); #1; instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sw_mem_write", {31'd0, MemWrite}, 32'd1);
    rst = 1'b0; #1;
    chk("rst_mem_write", {31'd0, MemWrite}, 32'd0);
    chk("rst_instr_q", instr_q, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    mcount = 32'd0;
    @(posedge clk); #1; rst = 1'b1; #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; instr_valid = 1'b0; instruction = 32'd0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_instr_q", instr_q, 32'd0);
    chk("reset_count", instr_count, 32'd0);
    chk("reset_ctrl", {26'd0, ALUScr, RegDst, RegWrite, MemRead, MemWrite, MemtoReg}, 32'd0);
    chk("reset_aluctl", {28'd0, ALUControl}, 32'd0);
    chk("reset_pulses", {29'd0, done, illegal, branch_taken}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;

    issue(32'h8C08_0005, 1'b0, 0);
    issue(32'h0232_4820, 1'b0, 1);
    issue(32'h0232_5022, 1'b0, 0);
    issue(32'h1232_0003, 1'b1, 0);
    issue(32'h1232_0003, 1'b0, 2);
    issue(32'hFC00_0000, 1'b0, 0);
    issue(32'h2008_0007, 1'b0, 0);
    issue(32'hAC09_0004, 1'b0, 0);
    issue(32'h0232_482A, 1'b0, 1);
    for (int n = 0; n < 120; n++) begin
      issue(gen(), 1'($urandom), $urandom_range(0, 2));
    end

    reset_mid_sw();
    issue(32'h0232_4824, 1'b0, 0);
    issue(32'h8C08_0005, 1'b0, 1);
    issue(32'h0232_4825, 1'b0, 0);
    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
